dual_period_meter: RTL

Source side of the two 8-bit measurement buses consumed by the hysteresis comparator: converts two pulse trains into saturating 8-bit period values `ts1`/`ts2`. The value 0 means "no valid measurement yet", which matches the comparator's rule of acting only when both inputs are non-zero. One update strobe per channel marks each new value.

---
 rtl/dpm_pkg.sv | 14 +
 rtl/period_channel.sv | 88 ++++++++
 rtl/dual_period_meter.sv | 55 +++++
 3 files changed

// File: rtl/dpm_pkg.sv
// Shared types and constants for the dual period meter.
// Build option: DPM_SYNC_EN adds a two-flop input synchronizer per channel.
package dpm_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        MEAS = 1'b1
    } chan_state_t;

    localparam int TS_W = 8;
    localparam logic [TS_W-1:0] TS_MAX     = 8'd255;
    localparam logic [TS_W-1:0] TS_INVALID = 8'd0;

endpackage

// File: rtl/period_channel.sv
// One measurement channel: optional synchronizer, rising-edge detect, IDLE/MEAS
// FSM, tick counter and the registered period/strobe outputs.
// Build option: DPM_SYNC_EN inserts a two-flop synchronizer on p.
// Output interface: upd is a valid-only strobe with no ready/backpressure; ts
// is meaningful in the cycle upd is high and holds its value until the next upd.
module period_channel
    import dpm_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            tick,
    input  logic            p,
    output logic [TS_W-1:0] ts,
    output logic            upd,
    output chan_state_t     state
);

    logic            smp;
    logic            smp_q;
    logic            edge_det;
    logic [TS_W-1:0] cnt;

`ifdef DPM_SYNC_EN
    logic sync_meta;

    // Two-flop synchronizer; the second flop is the current edge-detect sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_meta <= 1'b0;
            smp       <= 1'b0;
        end else begin
            sync_meta <= p;
            smp       <= sync_meta;
        end
    end
`else
    // Input is already synchronous: sample it straight into the edge-detect register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) smp <= 1'b0;
        else      smp <= p;
    end
`endif

    // Previous sample; reset to 0 so a high input right after reset counts as an edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) smp_q <= 1'b0;
        else      smp_q <= smp;
    end

    assign edge_det = smp & ~smp_q;

    // Channel FSM: an edge always beats a coincident tick; cnt saturates into a timeout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            ts    <= TS_INVALID;
            upd   <= 1'b0;
        end else begin
            upd <= 1'b0;
            case (state)
                IDLE: begin
                    if (edge_det) begin
                        state <= MEAS;
                        cnt   <= '0;
                    end
                end
                MEAS: begin
                    if (edge_det) begin
                        ts  <= (cnt == '0) ? 8'd1 : cnt;
                        upd <= 1'b1;
                        cnt <= '0;
                    end else if (tick) begin
                        if (cnt != TS_MAX) begin
                            cnt <= cnt + 8'd1;
                        end else begin
                            ts    <= TS_MAX;
                            upd   <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/dual_period_meter.sv
// Two independent pulse-period meters sharing one prescaler tick.
// Build option: DPM_SYNC_EN adds a two-flop synchronizer on p1 and p2.
// st1/st2 expose each channel's FSM state for debug.
module dual_period_meter
    import dpm_pkg::*;
#(
    parameter int unsigned PRESCALE = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            p1,
    input  logic            p2,
    output logic [TS_W-1:0] ts1,
    output logic [TS_W-1:0] ts2,
    output logic            upd1,
    output logic            upd2,
    output chan_state_t     st1,
    output chan_state_t     st2
);

    localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

    logic [15:0] pcnt;
    logic        tick;

    assign tick = (pcnt == PS_LAST);

    // Free-running prescaler 0..PRESCALE-1; tick marks the last count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      pcnt <= '0;
        else if (tick) pcnt <= '0;
        else           pcnt <= pcnt + 16'd1;
    end

    period_channel u_ch1 (
        .clk   (clk),
        .rst   (rst),
        .tick  (tick),
        .p     (p1),
        .ts    (ts1),
        .upd   (upd1),
        .state (st1)
    );

    period_channel u_ch2 (
        .clk   (clk),
        .rst   (rst),
        .tick  (tick),
        .p     (p2),
        .ts    (ts2),
        .upd   (upd2),
        .state (st2)
    );

endmodule
